dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single data memory between the CPU data port and an auxiliary requester such as a DMA or video reader. It sits between `top`'s data-memory interface and the memory instance. It grants one access per cycle, routes read data back to the owner one cycle later and bounds auxiliary starvation. The CPU gets priority; the auxiliary port is guaranteed service after a programmable number of denied cycles.

## Interface
Parameters:
- `ADDR_W`, 32: address width, both ports and memory.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive contested cycles the aux port may lose before it is forced to win. Legal range is ≥1.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: asynchronous, active-low (0 = reset asserted).
- `cpu_req`, `cpu_we`  in  1: CPU access request and write enable.
- `cpu_addr`  in  ADDR_W; `cpu_wdata`  in  DATA_W.
- `cpu_gnt`  out  1: CPU access accepted this cycle.
- `cpu_stall`  out  1: `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`  out  1; `cpu_rdata`  out  DATA_W: read return.
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`, `aux_gnt`, `aux_rvalid`, `aux_rdata`: same meaning and widths as the CPU port.
- `mem_en`, `mem_we`  out  1; `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W.
- `mem_rdata`  in  DATA_W: memory read data, registered, valid 1 cycle after `mem_en & ~mem_we`.

## Operation
- **Grant** (combinational from requests and state):
  - Only `cpu_req`: the CPU wins.
  - Only `aux_req`: aux wins.
  - Both: the CPU wins unless `starve_cnt == STARVE_LIMIT`, in which case aux wins.
  - Neither: no grant.
  - At most one `gnt` is high at a time.
- **Request rule:**
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - The transfer completes on the rising edge where `req & gnt` are both high.
  - Dropping `req` before `gnt` is legal and cancels the request.
- **Memory mux:**
  - `mem_en = cpu_gnt | aux_gnt`.
  - `mem_we`, `mem_addr` and `mem_wdata` come from the winner; they are 0 when there is no grant.
- **Starvation counter** `starve_cnt`, width `$clog2(STARVE_LIMIT+1)`:
  - Increments when `cpu_req & aux_req & cpu_gnt`.
  - Clears to 0 when `aux_gnt` or `~aux_req`.
  - Otherwise holds.
  - Saturates at `STARVE_LIMIT`; it never wraps.
- **Read return:**
  - On a granted read, the owner tag register `rd_owner` loads CPU or AUX. Otherwise it loads NONE.
  - Next cycle, `x_rvalid = (rd_owner == x)`.
  - Both `cpu_rdata` and `aux_rdata` equal `mem_rdata` unconditionally. Consumers qualify with `rvalid`.
- **Writes** produce no `rvalid`.
- **Back-to-back reads** are allowed every cycle, including alternating owners. Each return is tagged correctly.

## Timing
- Grant latency: 0 cycles (same-cycle `gnt`).
- Read latency: 1 cycle from the granting edge to `rvalid`.
- Reset values while `reset == 0`:
  - `starve_cnt = 0`, `rd_owner = NONE`.
  - All `gnt`, `rvalid` and `mem_en` are 0, and `cpu_stall` is 0; grants are masked during reset.
- Reset asserted mid-read: the pending `rvalid` is discarded. No `rvalid` is produced after reset releases.
- Simultaneous requests when `starve_cnt == STARVE_LIMIT`:
  - The aux port wins.
  - The counter clears on that edge.
  - The CPU wins the following contested cycle.
- After a forced aux win, the CPU stalls for at most one cycle per `STARVE_LIMIT+1` contested cycles.

## Structure
- Package `dmem_arb_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_AUX} owner_e`.
  - Default `STARVE_LIMIT` constant.
- Sub-module `arb_starve_ctr`:
  - Parameterised saturating counter with `inc`, `clr` and `at_limit`.
  - Instantiated once.

## Test plan
- **CPU alone:** CPU writes 7 to address 100 → `cpu_gnt=1` the same cycle, `mem_we=1`, `mem_addr=100`, `mem_wdata=7`, no `rvalid`. A following CPU read of address 100 → `cpu_rvalid=1` one cycle later with `cpu_rdata=7`.
- **Contention:** both request every cycle with `STARVE_LIMIT=4` → grant pattern CPU, CPU, CPU, CPU, AUX, repeating. `cpu_stall=1` only on the AUX cycles.
- **Interleaved reads:** CPU reads address 0x60 (holding 3), then aux reads 0x64 (holding 7) on the next cycle → `cpu_rvalid` with 3, then `aux_rvalid` with 7. The other port's `rvalid` stays 0 each time.
- **Counter clear:** aux drops `req` after 2 losses, then re-requests → `starve_cnt` clears to 0, and 4 further CPU wins are needed before aux is forced.
- **Reset mid-read:** aux read granted, then `reset=0` before the next edge → `aux_rvalid` stays 0 and all outputs are 0. After release, the first grant behaves normally.
- **Idle:** no requests for 10 cycles → `mem_en=0`, `mem_addr=0` and `starve_cnt=0` throughout.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;
   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_AUX} owner_e;
   localparam int STARVE_LIMIT_DEF = 4;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating count of contested cycles lost by the aux port.
module arb_starve_ctr #(
   parameter int LIMIT = 4,
   parameter int W = $clog2(LIMIT + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         at_limit
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      at_limit = cnt_q == W'(LIMIT);
      cnt_d = clr ? '0 : (inc && !at_limit) ? cnt_q + W'(1) : cnt_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign cnt = cnt_q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the CPU and an aux requester,
// CPU first, aux forced through after STARVE_LIMIT lost contested cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              aux_req,
   input  logic              aux_we,
   input  logic [ADDR_W-1:0] aux_addr,
   input  logic [DATA_W-1:0] aux_wdata,
   output logic              aux_gnt,
   output logic              aux_rvalid,
   output logic [DATA_W-1:0] aux_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   logic [CW-1:0] starve_cnt;
   logic at_limit, aux_win, cnt_inc, cnt_clr;
   owner_e rd_owner_q, rd_owner_d;
   // reset is folded into the grants so nothing reaches memory while held
   always_comb begin
      aux_win    = aux_req & (~cpu_req | at_limit);
      cpu_gnt    = reset & cpu_req & ~aux_win;
      aux_gnt    = reset & aux_win;
      cpu_stall  = reset & cpu_req & ~cpu_gnt;
      mem_en     = cpu_gnt | aux_gnt;
      mem_we     = cpu_gnt ? cpu_we : aux_gnt ? aux_we : 1'b0;
      mem_addr   = cpu_gnt ? cpu_addr : aux_gnt ? aux_addr : '0;
      mem_wdata  = cpu_gnt ? cpu_wdata : aux_gnt ? aux_wdata : '0;
      cnt_inc    = cpu_req & aux_req & cpu_gnt;
      cnt_clr    = aux_gnt | ~aux_req;
      rd_owner_d = (cpu_gnt & ~cpu_we) ? OWN_CPU : (aux_gnt & ~aux_we) ? OWN_AUX : OWN_NONE;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) rd_owner_q <= OWN_NONE;
      else rd_owner_q <= rd_owner_d;
   arb_starve_ctr #(.LIMIT(STARVE_LIMIT), .W(CW)) u_starve (
      .clk(clk),
      .rst_n(reset),
      .inc(cnt_inc),
      .clr(cnt_clr),
      .cnt(starve_cnt),
      .at_limit(at_limit)
   );
   assign cpu_rvalid = rd_owner_q == OWN_CPU;
   assign aux_rvalid = rd_owner_q == OWN_AUX;
   assign cpu_rdata  = mem_rdata;
   assign aux_rdata  = mem_rdata;
endmodule
